// File: rtl/phy_pkg.sv
// Shared PHY datapath widths and the byte-index type used by the
// 8<->32 serializer/deserializer pair.
package phy_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef logic [IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

endpackage : phy_pkg

// File: rtl/deser_8_32.sv
// Byte-to-word deserializer: packs four bytes (first byte in the MSBs) into a
// 32-bit word, strobing valid_out on completion and err_partial on a cut-short word.
module deser_8_32
  import phy_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              err_partial
);

  localparam int unsigned ACC_W = WORD_W - BYTE_W;

  byte_idx_t        idx;
  logic [ACC_W-1:0] acc;

  // Byte assembly; data_in is only looked at while valid_in is high.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      acc         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      err_partial <= 1'b0;
      if (valid_in) begin
        case (idx)
          2'd0: begin
            acc[23:16] <= data_in;
            idx        <= 2'd1;
          end
          2'd1: begin
            acc[15:8] <= data_in;
            idx       <= 2'd2;
          end
          2'd2: begin
            acc[7:0] <= data_in;
            idx      <= LAST_IDX;
          end
          default: begin
            data_out  <= {acc, data_in};
            valid_out <= 1'b1;
            idx       <= '0;
          end
        endcase
      end else begin
        // Any collected bytes are dropped; acc and data_out keep their values.
        err_partial <= (idx != '0);
        idx         <= '0;
      end
    end
  end

endmodule : deser_8_32

// File: tb/tb_deser_8_32.sv
// Directed self-checking bench for deser_8_32.
module tb_deser_8_32;
  import phy_pkg::*;

  logic              clk_4f;
  logic              reset;
  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic              err_partial;

  int checks = 0;
  int errors = 0;

  deser_8_32 dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .err_partial (err_partial)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk_4f);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  // Serializer model: MSB byte first, no gaps; checks the single completion strobe.
  task automatic send_word(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[8*(3-i) +: 8]);
      if (i < 3) chk1({tag, "_vmid"}, valid_out, 1'b0);
    end
    chk1({tag, "_vout"}, valid_out, 1'b1);
    chk32({tag, "_data"}, data_out, w);
    chk1({tag, "_err"}, err_partial, 1'b0);
  endtask

  initial begin
    logic [7:0]  b2b [8];
    logic [31:0] prev;
    logic [31:0] w;

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #1;
    chk32("rst_data", data_out, 32'h0);
    chk1("rst_vout", valid_out, 1'b0);
    chk1("rst_err", err_partial, 1'b0);
    @(negedge clk_4f);
    reset = 1'b0;

    // 1. Word assembly
    step(1'b1, 8'hDE); chk1("t1_v0", valid_out, 1'b0);
    step(1'b1, 8'hAD); chk1("t1_v1", valid_out, 1'b0);
    step(1'b1, 8'hBE); chk1("t1_v2", valid_out, 1'b0);
    chk32("t1_hold0", data_out, 32'h0);
    step(1'b1, 8'hEF);
    chk1("t1_vout", valid_out, 1'b1);
    chk32("t1_data", data_out, 32'hDEADBEEF);
    step(1'b0, 8'h00);
    chk1("t1_vdrop", valid_out, 1'b0);
    chk1("t1_err", err_partial, 1'b0);
    chk32("t1_hold", data_out, 32'hDEADBEEF);

    // 2. Back-to-back words
    b2b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, b2b[i]);
      chk1("t2_err", err_partial, 1'b0);
      chk1("t2_vout", valid_out, (i == 3 || i == 7));
      if (i >= 3 && i < 7) chk32("t2_word0", data_out, 32'h01020304);
    end
    chk32("t2_word1", data_out, 32'h11121314);

    // 3. Partial word
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b0, 8'h00);
    chk1("t3_err_first", err_partial, 1'b1);
    chk1("t3_vout", valid_out, 1'b0);
    chk32("t3_hold", data_out, 32'h11121314);
    step(1'b0, 8'h00);
    chk1("t3_err_second", err_partial, 1'b0);
    step(1'b0, 8'h00);
    chk1("t3_err_third", err_partial, 1'b0);
    chk32("t3_hold2", data_out, 32'h11121314);
    send_word("t3_next", 32'hCAFEBABE);

    // 4. Reset mid-word, asserted between edges
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    #2;
    reset = 1'b1;
    #1;
    chk32("t4_rst_data", data_out, 32'h0);
    chk1("t4_rst_vout", valid_out, 1'b0);
    chk1("t4_rst_err", err_partial, 1'b0);
    @(negedge clk_4f);
    valid_in = 1'b0;
    @(posedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    step(1'b0, 8'h00);
    chk1("t4_no_err", err_partial, 1'b0);
    send_word("t4_word", 32'h56789ABC);

    // 5. Idle noise, including X on data_in
    prev = 32'h56789ABC;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00);
      chk1("t5_vout", valid_out, 1'b0);
      chk1("t5_err", err_partial, 1'b0);
      chk32("t5_data", data_out, prev);
    end
    step(1'b0, 8'hxx);
    chk32("t5_x_data", data_out, prev);
    chk1("t5_x_vout", valid_out, 1'b0);
    chk1("t5_x_err", err_partial, 1'b0);

    // 6. Loopback from a serializer model
    send_word("t6_fixed", 32'h0BADF00D);
    step(1'b0, 8'h00);
    chk1("t6_single", valid_out, 1'b0);
    for (int n = 0; n < 100; n++) begin
      w = $urandom;
      send_word("t6_rand", w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_deser_8_32

// File: doc/deser_8_32.md
# deser_8_32

Byte-to-word deserializer on the PHY receive path. Accepts a byte stream at clk_4f, most-significant byte first, four bytes per word, with the byte sequence restarting whenever valid drops. Each completed 32-bit word is presented with a one-cycle valid strobe. Words that are cut short are discarded and flagged.

## Interface
- No parameters. Widths come from the shared package: BYTE_W = 8, WORD_W = 32, BYTES_PER_WORD = 4.
- clk_4f  input  1  byte-rate clock; all state changes on rising edge.
- reset  input  1  One clock; reset is asynchronous and active-high.
- data_in  input  8  incoming byte; sampled only when valid_in = 1.
- valid_in  input  1  byte qualifier; 0 terminates the current word.
- data_out  output  32  last completed word, {byte0, byte1, byte2, byte3}; byte0 = first received.
- valid_out  output  1  one-cycle strobe, high the cycle after a word completes.
- err_partial  output  1  one-cycle strobe; a word was abandoned with 1–3 bytes collected.

## Operation
- State: byte index idx (2 bits, 0..3), assembly register acc (24 bits, first three bytes), output registers.
- Reset (async, while reset = 1): idx = 0, acc = 0, data_out = 32'h0, valid_out = 0, err_partial = 0.
- On each edge with valid_in = 1:
  - idx = 0: acc[23:16] <= data_in; idx <= 1.
  - idx = 1: acc[15:8] <= data_in; idx <= 2.
  - idx = 2: acc[7:0] <= data_in; idx <= 3.
  - idx = 3: data_out <= {acc, data_in}; valid_out <= 1; idx <= 0.
- On each edge with valid_in = 0:
  - idx <= 0.
  - err_partial <= 1 iff idx ∈ {1,2,3}.
  - data_out and acc hold.
  - data_in is ignored regardless of value.
- valid_out and err_partial default to 0 on every edge not listed above.
- data_out changes only on word completion and holds between completions.
- A partial word never reaches data_out.

## Timing
- Latency: byte3 is sampled on edge N; data_out and valid_out = 1 are visible after edge N; valid_out returns to 0 after edge N+1 unless another word completes on N+1 (impossible at 4 bytes/word).
- Back-to-back words need no gap: byte0 of the next word may follow byte3 on the very next edge.
- Minimum spacing between valid_out pulses is 4 cycles.
- Idle (valid_in = 0) with idx = 0 produces no strobes.
- Only the first idle cycle after a partial word raises err_partial. Later idle cycles keep err_partial at 0, because idx is already 0.
- valid_in low then high: the next valid byte is always byte0.
- Reset asserted mid-word: all state clears immediately, without waiting for a clock. No err_partial is raised for the lost bytes. After reset deasserts, the first valid byte is byte0.
- data_in with X while valid_in = 0 must not propagate to any output.

## Structure
- Shared package phy_pkg: BYTE_W, WORD_W, BYTES_PER_WORD, and a typedef for the 2-bit byte index. The matching 32-to-8 serializer uses the same package.
- A single flat module. idx, acc and the output registers are all in one clocked process with async reset; no sub-module is warranted.
- Loopback environment: the serializer drives this block directly (data_out→data_in, valid_out→valid_in), closing the 32→8→32 round trip.

## Test plan
1. Word assembly: reset, then valid_in = 1 with bytes DE, AD, BE, EF on consecutive edges.
   - Required: data_out = 32'hDEADBEEF with valid_out = 1 for exactly one cycle, after the 4th edge.
2. Back-to-back words: bytes 01 02 03 04 11 12 13 14, valid_in held high.
   - Required: 32'h01020304, then 32'h11121314 four cycles later; two valid_out pulses, err_partial stays 0.
3. Partial word: bytes AA, BB, then valid_in = 0 for 3 cycles, then CA FE BA BE.
   - Required: err_partial pulses once on the first idle edge; data_out holds its previous value; next word = 32'hCAFEBABE.
4. Reset mid-word: after bytes 12, 34, assert reset asynchronously between edges, then release and send 56 78 9A BC.
   - Required: outputs are zero immediately on reset; no err_partial; data_out = 32'h56789ABC.
5. Idle noise: valid_in = 0 with data_in toggling FF/00 for 8 cycles.
   - Required: no valid_out, no err_partial, data_out unchanged.
6. Loopback: serializer fed 32'h0BADF00D → this block.
   - Required: data_out = 32'h0BADF00D with one valid_out pulse; repeat with 100 random words and compare each.
